// File: rtl/skid_fifo.sv
// skid_fifo: DEPTH-entry elastic buffer between a memory response channel and
// a consumer. m_rsp_rdy is registered, and the producer may see it SKID cycles
// late. The threshold that drives m_rsp_rdy leaves room for those late beats.
// If BYPASS is set, an empty buffer passes the incoming beat straight to the
// head port. A beat that arrives while the buffer is full and not popping is
// dropped, and the sticky ovf flag is set.
module skid_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int SKID       = 1,
    parameter int BYPASS     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         m_rsp_vld,
    input  logic [DATA_WIDTH-1:0]        m_rsp_data,
    output logic                         m_rsp_rdy,
    output logic                         src_vld,
    output logic [DATA_WIDTH-1:0]        src_data,
    input  logic                         src_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // m_rsp_rdy stays high only while SKID more beats would still fit.
    localparam logic [CW-1:0] RDY_MAX  = CW'(DEPTH - 1 - SKID);
    localparam bit USE_BYPASS = (BYPASS != 0);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("skid_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (SKID < 0 || SKID >= DEPTH) begin : g_bad_skid
        $error("skid_fifo: SKID must satisfy 0 <= SKID < DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic                  ovf_q;
    logic                  rdy_q;

    logic                  empty;
    logic                  full;
    logic                  bypass_path;
    logic                  pop;
    logic                  push;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drop;

    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign bypass_path = USE_BYPASS && empty;

    // Head port: bypass shows the incoming beat, otherwise the oldest entry.
    always_comb begin
        src_vld  = !empty;
        src_data = mem[rd_ptr];
        if (bypass_path) begin
            src_vld  = m_rsp_vld;
            src_data = m_rsp_data;
        end
    end

    // Handshake decode. The consumer may take a bypassed beat in the cycle it
    // arrives; that beat is then neither written nor read from storage.
    always_comb begin
        pop   = src_vld && src_rdy;
        push  = m_rsp_vld && (!full || pop);
        wr_en = push && !(bypass_path && pop);
        rd_en = pop && !bypass_path;
        drop  = m_rsp_vld && full && !pop;
    end

    // Next occupancy. It feeds both the count register and the registered ready.
    always_comb begin
        count_next = count_q;
        if (rst || flush) begin
            count_next = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_next = count_q + CW'(1);
                2'b01:   count_next = count_q - CW'(1);
                default: count_next = count_q;
            endcase
        end
    end

    // Write and read pointers plus occupancy. Reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_next;
        end
    end

    // Storage write. The array has no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush) begin
            mem[wr_ptr] <= m_rsp_data;
        end
    end

    // Sticky overflow. Only rst clears it, and a beat lost to flush does not count as a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop && !flush) begin
            ovf_q <= 1'b1;
        end
    end

    // Registered ready, computed from the occupancy the buffer will hold next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= (count_next <= RDY_MAX);
        end
    end

    assign m_rsp_rdy = rdy_q;
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_skid_fifo.sv
// tb_skid_fifo: drives one BYPASS=0 and one BYPASS=1 instance (DEPTH=4, SKID=1)
// with the same stimulus. Each instance is checked against a list-based model
// of the buffer's occupancy, ordering, overflow and ready rules.
module tb_skid_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SKID  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          m_rsp_vld = 1'b0;
    logic [DW-1:0] m_rsp_data = '0;
    logic          src_rdy = 1'b0;

    logic          rdy_a, vld_a, ovf_a;
    logic [DW-1:0] data_a;
    logic [2:0]    cnt_a;
    logic          rdy_b, vld_b, ovf_b;
    logic [DW-1:0] data_b;
    logic [2:0]    cnt_b;

    always #5 clk = ~clk;

    skid_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKID(SKID), .BYPASS(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .m_rsp_vld(m_rsp_vld), .m_rsp_data(m_rsp_data), .m_rsp_rdy(rdy_a),
        .src_vld(vld_a), .src_data(data_a), .src_rdy(src_rdy),
        .count(cnt_a), .ovf(ovf_a)
    );

    skid_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKID(SKID), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .m_rsp_vld(m_rsp_vld), .m_rsp_data(m_rsp_data), .m_rsp_rdy(rdy_b),
        .src_vld(vld_b), .src_data(data_b), .src_rdy(src_rdy),
        .count(cnt_b), .ovf(ovf_b)
    );

    int unsigned nchk = 0;
    int unsigned npass = 0;

    // Reference model: one ordered list per instance, with the head at index 0.
    logic [DW-1:0] mq [2][0:7];
    int unsigned   mn [2];
    bit            mo [2];
    bit            mr [2];
    bit            known = 1'b0;

    // Values sampled in the most recent step, used by the directed checks.
    logic [2:0]    o_cnt  [2];
    logic          o_vld  [2];
    logic [DW-1:0] o_data [2];
    logic          o_ovf  [2];
    logic          o_rdy  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive the inputs at negedge, check both instances, then advance the model.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit sr, input bit fl, input bit rs);
        bit            byp, emp, ev, pop, acc;
        logic [DW-1:0] ed;
        @(negedge clk);
        m_rsp_vld  = v;
        m_rsp_data = d;
        src_rdy    = sr;
        flush      = fl;
        rst        = rs;
        #1;
        o_cnt[0] = cnt_a;  o_vld[0] = vld_a;  o_data[0] = data_a;  o_ovf[0] = ovf_a;  o_rdy[0] = rdy_a;
        o_cnt[1] = cnt_b;  o_vld[1] = vld_b;  o_data[1] = data_b;  o_ovf[1] = ovf_b;  o_rdy[1] = rdy_b;
        for (int i = 0; i < 2; i++) begin
            byp = (i == 1);
            emp = (mn[i] == 0);
            ev  = (byp && emp) ? v : !emp;
            ed  = (byp && emp) ? d : mq[i][0];
            if (known) begin
                chk(i == 0 ? "count_a" : "count_b", {29'd0, o_cnt[i]}, mn[i]);
                chk(i == 0 ? "src_vld_a" : "src_vld_b", {31'd0, o_vld[i]}, {31'd0, ev});
                if (ev) chk(i == 0 ? "src_data_a" : "src_data_b", {24'd0, o_data[i]}, {24'd0, ed});
                chk(i == 0 ? "ovf_a" : "ovf_b", {31'd0, o_ovf[i]}, {31'd0, mo[i]});
                chk(i == 0 ? "m_rsp_rdy_a" : "m_rsp_rdy_b", {31'd0, o_rdy[i]}, {31'd0, mr[i]});
            end
            if (rs) begin
                mn[i] = 0;
                mo[i] = 1'b0;
                mr[i] = 1'b1;
            end else begin
                pop = ev && sr;
                if (fl) begin
                    mn[i] = 0;
                end else if (byp && emp) begin
                    if (v && !sr) begin
                        mq[i][0] = d;
                        mn[i] = 1;
                    end
                end else begin
                    acc = v && (mn[i] < DEPTH || pop);
                    if (pop) begin
                        for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                        mn[i]--;
                    end
                    if (acc) begin
                        mq[i][mn[i]] = d;
                        mn[i]++;
                    end
                    if (v && !acc) mo[i] = 1'b1;
                end
                mr[i] = (mn[i] <= DEPTH - 1 - SKID);
            end
        end
        if (rs) known = 1'b1;
    endtask

    initial begin
        bit rdy_d;

        // Reset held for two cycles with a beat offered
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_count", {29'd0, o_cnt[i]}, 32'd0);
            chk("rst_src_vld", {31'd0, o_vld[i]}, 32'd0);
            chk("rst_rdy", {31'd0, o_rdy[i]}, 32'd1);
            chk("rst_ovf", {31'd0, o_ovf[i]}, 32'd0);
        end

        // Streaming 0x00..0x0F with the consumer always ready
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_rdy", {31'd0, o_rdy[0]}, 32'd1);
            chk("stream_cnt_le1", {31'd0, (o_cnt[0] <= 3'd1)}, 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Backpressure: the producer follows m_rsp_rdy one cycle late
        rdy_d = o_rdy[0];
        for (int i = 0; i < 8; i++) begin
            step(rdy_d, 8'($urandom), 1'b0, 1'b0, 1'b0);
            rdy_d = o_rdy[0];
        end
        chk("bp_ovf", {31'd0, o_ovf[0]}, 32'd0);
        chk("bp_cnt_le_depth", {31'd0, (o_cnt[0] <= 3'd4)}, 32'd1);
        chk("bp_rdy_low", {31'd0, o_rdy[0]}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Overflow: six beats into a four-entry buffer
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", {29'd0, o_cnt[0]}, 32'd4);
        chk("ovf_flag", {31'd0, o_ovf[0]}, 32'd1);
        chk("ovf_head", {24'd0, o_data[0]}, 32'h40);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Full buffer with a simultaneous push and pop for eight cycles
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h90 + i), 1'b1, 1'b0, 1'b0);
            chk("full_pp_count", {29'd0, o_cnt[0]}, 32'd4);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("full_pp_ovf", {31'd0, o_ovf[0]}, 32'd0);
        chk("full_pp_head", {24'd0, o_data[0]}, 32'h94);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Bypass: the beat reaches the consumer in the cycle it arrives
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("byp_vld", {31'd0, o_vld[1]}, 32'd1);
        chk("byp_data", {24'd0, o_data[1]}, 32'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("byp_count", {29'd0, o_cnt[1]}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with three entries stored and ovf already set
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("pre_flush_count", {29'd0, o_cnt[0]}, 32'd3);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("flush_count", {29'd0, o_cnt[0]}, 32'd0);
        chk("flush_keeps_ovf", {31'd0, o_ovf[0]}, 32'd1);
        chk("flush_rdy", {31'd0, o_rdy[0]}, 32'd1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
